// File: rtl/lsu_bus_master_pkg.sv
// lsu_bus_master_pkg: shared size encodings, data width and FSM state type for the LSU bus master
package lsu_bus_master_pkg;
  localparam int DATA_W = 32;
  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
endpackage

// File: rtl/lsu_bus_master_if.sv
// lsu_bus_master_if: req/gnt data bus between the LSU (master) and a target (slave)
// Signals: req, addr, hb, we, wdata driven by master; rdata (right-aligned per hb) and gnt driven by slave.
interface lsu_bus_master_if;
  import lsu_bus_master_pkg::*;
  logic              req;
  logic [DATA_W-1:0] addr;
  logic [1:0]        hb;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              gnt;
  modport master (output req, addr, hb, we, wdata, input rdata, gnt);
  modport slave  (input req, addr, hb, we, wdata, output rdata, gnt);
endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: combinational zero/sign extension of right-aligned load data by access size
// Ports: i_data raw data, i_hb size (00 byte, 01 half, 1x word), i_unsigned zero-extend select, o_data result.
module lsu_load_ext
  import lsu_bus_master_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_hb,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data
);
  logic w_sb, w_sh;
  assign w_sb = ~i_unsigned & i_data[7];
  assign w_sh = ~i_unsigned & i_data[15];
  assign o_data = i_hb == HB_BYTE ? {{24{w_sb}}, i_data[7:0]} :
                  i_hb == HB_HALF ? {{16{w_sh}}, i_data[15:0]} : i_data;
endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: single-outstanding load/store initiator on the req/gnt bus with timeout and load extension
// Core side: clk_i, rst_i (async active-high), valid_i/we_i/addr_i/size_i/unsigned_i/wdata_i in,
//   ready_o/done_o/err_o/rdata_o out. Bus side: lsu_bus_master_if.master port bus.
// Optional: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses without touching the bus.
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  lsu_bus_master_if.master  bus
);
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ready, r_done, r_err, r_req, r_we, r_uns;
  logic [1:0]        r_hb;
  logic [DATA_W-1:0] r_addr, r_wdata, r_rdata, w_ext;
  lsu_load_ext u_ext (.i_data(bus.rdata), .i_hb(r_hb), .i_unsigned(r_uns), .o_data(w_ext));
`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = (size_i == HB_HALF && addr_i[0]) || (size_i[1] && addr_i[1:0] != 2'b00);
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_hb    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else
      case (r_state)
        S_IDLE: if (valid_i) begin
          r_addr  <= addr_i;
          r_hb    <= size_i;
          r_we    <= we_i;
          r_wdata <= wdata_i;
          r_uns   <= unsigned_i;
          r_cnt   <= '0;
          r_ready <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          if (w_misalign) begin
            r_state <= S_RESP;
            r_err   <= 1'b1;
          end else begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
`else
          r_state <= S_REQ;
          r_req   <= 1'b1;
`endif
        end
        S_REQ: if (bus.gnt) begin
          r_state <= S_RESP;
          r_req   <= 1'b0;
          r_done  <= 1'b1;
          if (!r_we) r_rdata <= w_ext;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          r_state <= S_RESP;
          r_req   <= 1'b0;
          r_err   <= 1'b1;
        end else
          r_cnt <= r_cnt + 1'b1;
        S_RESP: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
  assign ready_o   = r_ready;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign rdata_o   = r_rdata;
  assign bus.req   = r_req;
  assign bus.addr  = r_addr;
  assign bus.hb    = r_hb;
  assign bus.we    = r_we;
  assign bus.wdata = r_wdata;
endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: directed vectors checked each cycle against a transaction-timing model of the LSU
module tb_lsu_bus_master;
  localparam int TO = 16;
  logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, we = 1'b0, uns = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  size = '0;
  logic        ready, done, err;
  logic [31:0] rdata;
  lsu_bus_master_if bus ();
  lsu_bus_master #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .we_i(we), .addr_i(addr), .size_i(size),
    .unsigned_i(uns), .wdata_i(wdata), .ready_o(ready), .done_o(done), .err_o(err),
    .rdata_o(rdata), .bus(bus)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] s, input bit u);
    int v;
    if (s == 2'b00) v = u ? int'(d[7:0]) : int'($signed(d[7:0]));
    else if (s == 2'b01) v = u ? int'(d[15:0]) : int'($signed(d[15:0]));
    else v = int'(d);
    return 32'(v);
  endfunction
  int          cyc = 0, t_acc = 0, t_resp = -1;
  bit          busy = 0, m_err = 0, m_we = 0, m_uns = 0, exp_req = 0, mis = 0;
  logic [31:0] m_rdata = '0, m_addr = '0, m_wdata = '0;
  logic [1:0]  m_size = '0;
  int          req_cnt = 0, done_lat = -1, err_lat = -1, done_n = 0, err_n = 0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      busy = 0;
      t_resp = -1;
      m_rdata = '0;
    end else begin
      exp_req = busy && cyc > t_acc && t_resp < 0;
      check("ready_o", ready, 32'(!busy));
      check("req_o", bus.req, 32'(exp_req));
      check("done_o", done, 32'(busy && cyc == t_resp && !m_err));
      check("err_o", err, 32'(busy && cyc == t_resp && m_err));
      check("rdata_o", rdata, m_rdata);
      if (exp_req) begin
        check("addr_o", bus.addr, m_addr);
        check("hb_o", 32'(bus.hb), 32'(m_size));
        check("we_o", 32'(bus.we), 32'(m_we));
        check("wdata_o", bus.wdata, m_wdata);
      end
      if (bus.req) req_cnt++;
      if (done) begin done_n++; done_lat = cyc - t_acc; end
      if (err) begin err_n++; err_lat = cyc - t_acc; end
      if (!busy) begin
        if (valid) begin
          busy = 1; t_acc = cyc; t_resp = -1; m_err = 0;
          m_addr = addr; m_size = size; m_we = we; m_wdata = wdata; m_uns = uns;
          req_cnt = 0; done_lat = -1; err_lat = -1;
`ifdef LSU_MISALIGN_TRAP_EN
          mis = (size == 2'b01 && addr[0]) || (size >= 2'b10 && addr[1:0] != 2'b00);
`else
          mis = 0;
`endif
          if (mis) begin t_resp = cyc + 1; m_err = 1; end
        end
      end else if (t_resp < 0) begin
        if (bus.gnt) begin
          t_resp = cyc + 1;
          if (!m_we) m_rdata = ext(bus.rdata, m_size, m_uns);
        end else if (cyc - t_acc == TO) begin
          t_resp = cyc + 1;
          m_err = 1;
        end
      end else if (cyc == t_resp) busy = 0;
    end
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic access(input bit w, input logic [31:0] a, input logic [1:0] s, input bit u,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd);
    valid = 1; we = w; addr = a; size = s; uns = u; wdata = wd;
    tick;
    valid = 0; we = ~w; addr = ~a; size = ~s; uns = ~u; wdata = ~wd;
    repeat (waits) tick;
    bus.gnt = 1; bus.rdata = rd;
    tick;
    bus.gnt = 0; bus.rdata = 32'h5A5A_5A5A;
    tick;
    tick;
  endtask
  typedef struct {logic [1:0] s; bit u; logic [31:0] rd; logic [31:0] exp;} vec_t;
  vec_t vecs[3] = '{
    '{2'b01, 1'b0, 32'h0000_8001, 32'hFFFF_8001},
    '{2'b00, 1'b1, 32'h0000_01F0, 32'h0000_00F0},
    '{2'b10, 1'b0, 32'h89AB_CDEF, 32'h89AB_CDEF}
  };
  int d0;
  initial begin
    bus.gnt = 0; bus.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst ready_o", ready, 1);
    check("rst req_o", bus.req, 0);
    check("rst done_o", done, 0);
    check("rst err_o", err, 0);
    check("rst rdata_o", rdata, 0);
    @(posedge clk); #2 rst = 0;
    tick;
    access(0, 32'h0000_0003, 2'b00, 0, 0, 0, 32'h0000_0080);
    check("sbyte rdata", rdata, 32'hFFFF_FF80);
    check("sbyte done latency", done_lat, 2);
    check("sbyte req cycles", req_cnt, 1);
    access(0, 32'h0000_0002, 2'b01, 1, 0, 3, 32'h0000_8001);
    check("uhalf req cycles", req_cnt, 4);
    check("uhalf rdata", rdata, 32'h0000_8001);
    d0 = done_n;
    access(1, 32'h0000_0010, 2'b10, 0, 32'hDEAD_BEEF, 0, 32'h1234_5678);
    check("store rdata kept", rdata, 32'h0000_8001);
    check("store done count", done_n - d0, 1);
    foreach (vecs[i]) begin
      access(0, 32'h0000_0100 + 4 * i, vecs[i].s, vecs[i].u, 0, i, vecs[i].rd);
      check("ext vector", rdata, vecs[i].exp);
    end
    d0 = err_n;
    access(0, 32'h0000_0020, 2'b10, 0, 0, 17, 32'hCAFE_F00D);
    check("timeout req cycles", req_cnt, 16);
    check("timeout err latency", err_lat, 17);
    check("timeout err count", err_n - d0, 1);
    check("timeout rdata kept", rdata, 32'h89AB_CDEF);
    access(0, 32'h0000_0006, 2'b10, 0, 0, 0, 32'h1122_3344);
`ifdef LSU_MISALIGN_TRAP_EN
    check("misalign req cycles", req_cnt, 0);
    check("misalign err latency", err_lat, 1);
`else
    check("misalign req cycles", req_cnt, 1);
    check("misalign rdata", rdata, 32'h1122_3344);
`endif
    d0 = done_n + err_n;
    valid = 1; we = 0; addr = 32'h0000_0040; size = 2'b10;
    tick;
    valid = 0;
    tick;
    #1 rst = 1;
    #1;
    check("midrst req_o", bus.req, 0);
    check("midrst ready_o", ready, 1);
    tick;
    tick;
    rst = 0;
    tick;
    tick;
    check("midrst no pulse", done_n + err_n - d0, 0);
    access(0, 32'h0000_0044, 2'b10, 0, 0, 1, 32'h0000_0055);
    check("post-reset rdata", rdata, 32'h0000_0055);
    check("post-reset done latency", done_lat, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
